// File: rtl/spi_shift_engine_if.sv
// Bundle of the SPI shift engine's FIFO handshakes, configuration and serial pins.
// The engine takes the master modport; the FIFOs, configuration and SPI slave side take the slave modport.
interface spi_shift_engine_if #(
  parameter int unsigned FIFOWIDTH = 32
);
  logic                 Enable;
  logic [7:0]           BaudDiv;
  logic [4:0]           WordSize;
  logic                 CPOL;
  logic                 CPHA;
  logic                 TxEmpty;
  logic [FIFOWIDTH-1:0] TxData;
  logic                 TxRead;
  logic                 RxFull;
  logic [FIFOWIDTH-1:0] RxData;
  logic                 RxWrite;
  logic                 RxDrop;
  logic                 Busy;
  logic                 SCLK;
  logic                 MOSI;
  logic                 MISO;
  logic                 CS_n;

  modport master (
    input  Enable, BaudDiv, WordSize, CPOL, CPHA, TxEmpty, TxData, RxFull, MISO,
    output TxRead, RxData, RxWrite, RxDrop, Busy, SCLK, MOSI, CS_n
  );

  modport slave (
    output Enable, BaudDiv, WordSize, CPOL, CPHA, TxEmpty, TxData, RxFull, MISO,
    input  TxRead, RxData, RxWrite, RxDrop, Busy, SCLK, MOSI, CS_n
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: pops TX words, shifts them MSB-first on MOSI/SCLK under CS_n,
// samples MISO in the same frame and pushes the received word to the RX FIFO.
module spi_shift_engine #(
  parameter int unsigned FIFOWIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  spi_shift_engine_if.master bus
);
  localparam int unsigned W    = FIFOWIDTH;
  localparam int unsigned DIVW = 8;
  localparam int unsigned CNTW = 6;
  localparam int unsigned WSW  = 5;

  typedef enum logic [2:0] {IDLE, POP, LOAD, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t          state;
  logic [DIVW-1:0] div_cnt;
  logic [DIVW-1:0] baud_q;
  logic [CNTW-1:0] edge_cnt;
  logic            shift_done;
  logic [WSW-1:0]  ws_q;
  logic            cpol_q;
  logic            cpha_q;
  logic [W-1:0]    tx_sreg;
  logic [W-1:0]    rx_sreg;
  logic [W-1:0]    rx_data;
  logic            tx_read;
  logic            rx_write;
  logic            rx_drop;
  logic            busy;
  logic            sclk;
  logic            mosi;
  logic            cs_n;

  logic [WSW-1:0]  ws_eff_c;
  logic [W-1:0]    tx_aligned_c;
  logic            tick_c;
  logic            odd_edge_c;
  logic            final_edge_c;
  logic            sample_c;
  logic            drive_c;

  // Word size clamped to the data width; TX word left-justified so bit N-1 sits at the MSB.
  assign ws_eff_c     = ({1'b0, bus.WordSize} >= 6'(W)) ? WSW'(W - 1) : bus.WordSize;
  assign tx_aligned_c = bus.TxData << (WSW'(W - 1) - ws_eff_c);

  assign tick_c       = (div_cnt == baud_q);
  assign odd_edge_c   = ~edge_cnt[0];
  assign final_edge_c = (edge_cnt == {ws_q, 1'b1});
  assign sample_c     = cpha_q ? ~odd_edge_c : odd_edge_c;
  assign drive_c      = cpha_q ? odd_edge_c : (~odd_edge_c & ~final_edge_c);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      baud_q     <= '0;
      edge_cnt   <= '0;
      shift_done <= 1'b0;
      ws_q       <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_sreg    <= '0;
      rx_sreg    <= '0;
      rx_data    <= '0;
      tx_read    <= 1'b0;
      rx_write   <= 1'b0;
      rx_drop    <= 1'b0;
      busy       <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
    end else begin
      tx_read  <= 1'b0;
      rx_write <= 1'b0;
      rx_drop  <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= bus.CPOL;
          if (bus.Enable && !bus.TxEmpty) begin
            state   <= POP;
            tx_read <= 1'b1;
            busy    <= 1'b1;
          end
        end
        POP: state <= LOAD;
        LOAD: begin
          baud_q     <= bus.BaudDiv;
          ws_q       <= ws_eff_c;
          cpol_q     <= bus.CPOL;
          cpha_q     <= bus.CPHA;
          sclk       <= bus.CPOL;
          rx_sreg    <= '0;
          cs_n       <= 1'b0;
          div_cnt    <= '0;
          edge_cnt   <= '0;
          shift_done <= 1'b0;
          if (!bus.CPHA) begin
            mosi    <= tx_aligned_c[W-1];
            tx_sreg <= {tx_aligned_c[W-2:0], 1'b0};
          end else begin
            tx_sreg <= tx_aligned_c;
          end
          state <= LEAD;
        end
        // LEAD ends with the first SCLK edge; SHIFT then holds one extra half-period after edge 2N.
        LEAD, SHIFT: begin
          if (tick_c) begin
            div_cnt <= '0;
            if (shift_done) begin
              state <= TRAIL;
            end else begin
              sclk <= ~sclk;
              if (sample_c) rx_sreg <= {rx_sreg[W-2:0], bus.MISO};
              if (drive_c) begin
                mosi    <= tx_sreg[W-1];
                tx_sreg <= {tx_sreg[W-2:0], 1'b0};
              end
              if (final_edge_c) shift_done <= 1'b1;
              else              edge_cnt   <= edge_cnt + CNTW'(1);
              state <= SHIFT;
            end
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        TRAIL: begin
          if (tick_c) begin
            div_cnt <= '0;
            cs_n    <= 1'b1;
            rx_data <= rx_sreg;
            if (bus.RxFull) rx_drop  <= 1'b1;
            else            rx_write <= 1'b1;
            state <= GAP;
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        GAP: begin
          if (tick_c) begin
            div_cnt <= '0;
            sclk    <= cpol_q;
            if (bus.Enable && !bus.TxEmpty) begin
              state   <= POP;
              tx_read <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TxRead  = tx_read;
  assign bus.RxData  = rx_data;
  assign bus.RxWrite = rx_write;
  assign bus.RxDrop  = rx_drop;
  assign bus.Busy    = busy;
  assign bus.SCLK    = sclk;
  assign bus.MOSI    = mosi;
  assign bus.CS_n    = cs_n;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: TX FIFO model, loopback or mode-aware SPI slave,
// frame timing monitors and hand-computed expectations.
module tb_spi_shift_engine;
  localparam int unsigned W = 32;

  logic Clock;
  logic Reset;

  spi_shift_engine_if #(.FIFOWIDTH(W)) bus ();

  spi_shift_engine #(.FIFOWIDTH(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  int          gaps[$];

  int   cyc = 0;
  int   tx_reads = 0;
  int   rx_writes = 0;
  int   rx_drops = 0;
  int   txread_empty = 0;
  int   t_txread = 0;
  int   t_csfall = 0;
  int   t_first_edge = 0;
  bit   edge_seen = 0;
  int   low_run = 0;
  int   high_run = 0;
  int   last_cs_low = 0;
  logic cs_prev = 1'b1;
  logic sclk_prev = 1'b0;
  int   e = 0;
  int   slv_n = 8;
  logic slave_bit = 1'b0;
  logic [31:0] slave_word = 32'h0;
  bit   loop = 1;
  logic [31:0] mosi_bits = 32'h0;
  int   rises = 0;

  int base_tx, base_wr, base_dr;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign bus.MISO = loop ? bus.MOSI : slave_bit;

  // TX FIFO registered output: data appears the cycle after the pop strobe.
  always @(posedge Clock) begin
    if (Reset) bus.TxData <= '0;
    else if (bus.TxRead && tx_q.size() > 0) bus.TxData <= tx_q.pop_front();
  end

  // Cycle bookkeeping, frame timing and slave MISO, all evaluated on the falling edge.
  always @(negedge Clock) begin
    int idx;
    cyc++;
    if (bus.TxRead && bus.TxEmpty) txread_empty++;
    if (bus.TxRead) begin tx_reads++; t_txread = cyc; end
    if (bus.RxWrite) begin rx_writes++; rx_q.push_back(bus.RxData); end
    if (bus.RxDrop) rx_drops++;
    if (bus.CS_n) begin
      if (!cs_prev) last_cs_low = low_run;
      low_run = 0;
      if (bus.Busy) high_run++;
      else          high_run = 0;
      e = 0;
    end else begin
      if (cs_prev) begin
        gaps.push_back(high_run);
        t_csfall  = cyc;
        edge_seen = 0;
      end
      high_run = 0;
      low_run++;
      if (bus.SCLK != sclk_prev) begin
        e++;
        if (!edge_seen) begin t_first_edge = cyc; edge_seen = 1; end
      end
    end
    idx = bus.CPHA ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
    slave_bit = (idx < slv_n) ? slave_word[slv_n-1-idx] : 1'b0;
    cs_prev   = bus.CS_n;
    sclk_prev = bus.SCLK;
    bus.TxEmpty = (tx_q.size() == 0);
  end

  always @(posedge bus.SCLK) begin
    if (bus.CS_n === 1'b0) begin
      mosi_bits = {mosi_bits[30:0], bus.MOSI};
      rises++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic wait_busy(input logic level, input int budget);
    int n = 0;
    while (bus.Busy !== level && n < budget) begin @(negedge Clock); n++; end
    if (bus.Busy !== level) check("wait_busy", 32'(bus.Busy), 32'(level));
  endtask

  task automatic wait_cs(input logic level, input int budget);
    int n = 0;
    while (bus.CS_n !== level && n < budget) begin @(negedge Clock); n++; end
    if (bus.CS_n !== level) check("wait_cs", 32'(bus.CS_n), 32'(level));
  endtask

  task automatic run_word(input logic [31:0] w);
    tx_q.push_back(w);
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 600);
    tick(1);
  endtask

  task automatic snap();
    base_tx = tx_reads; base_wr = rx_writes; base_dr = rx_drops;
    rx_q.delete(); gaps.delete(); mosi_bits = 32'h0; rises = 0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.Enable = 1'b0; bus.BaudDiv = 8'd1; bus.WordSize = 5'd7;
    bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.RxFull = 1'b0; bus.TxEmpty = 1'b1;
    loop = 1;
    tick(3);
    check("rst_txread",  32'(bus.TxRead),  32'd0);
    check("rst_rxwrite", 32'(bus.RxWrite), 32'd0);
    check("rst_rxdrop",  32'(bus.RxDrop),  32'd0);
    check("rst_busy",    32'(bus.Busy),    32'd0);
    check("rst_rxdata",  bus.RxData,       32'd0);
    check("rst_mosi",    32'(bus.MOSI),    32'd0);
    check("rst_sclk",    32'(bus.SCLK),    32'd0);
    check("rst_csn",     32'(bus.CS_n),    32'd1);
    Reset = 1'b0;
    tick(2);

    // Mode 0, BaudDiv=1, 8-bit 0xA5 looped back.
    bus.Enable = 1'b1;
    snap();
    run_word(32'hA5);
    check("m0_mosi_bits",  mosi_bits, 32'hA5);
    check("m0_rises",      32'(rises), 32'd8);
    check("m0_rxdata",     bus.RxData, 32'hA5);
    check("m0_rxwrites",   32'(rx_writes - base_wr), 32'd1);
    check("m0_txreads",    32'(tx_reads - base_tx), 32'd1);
    check("m0_cs_low",     32'(last_cs_low), 32'd36);
    check("m0_csfall_lat", 32'(t_csfall - t_txread), 32'd2);
    check("m0_edge1_lat",  32'(t_first_edge - t_csfall), 32'd2);

    // All four modes against a slave returning 0xC3.
    loop = 0; slave_word = 32'hC3; slv_n = 8;
    for (int m = 0; m < 4; m++) begin
      bus.CPOL = m[1]; bus.CPHA = m[0];
      tick(3);
      check($sformatf("mode%0d_idle_sclk", m), 32'(bus.SCLK), 32'(m[1]));
      snap();
      run_word(32'h3C);
      check($sformatf("mode%0d_rxdata", m), bus.RxData, 32'hC3);
    end
    bus.CPOL = 1'b0; bus.CPHA = 1'b0; loop = 1;

    // Back-to-back frames with BaudDiv=0.
    bus.Enable = 1'b0; bus.BaudDiv = 8'd0;
    tick(2);
    snap();
    tx_q.push_back(32'h11); tx_q.push_back(32'h22); tx_q.push_back(32'h33);
    tick(1);
    bus.Enable = 1'b1;
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 300);
    tick(1);
    check("b2b_txreads", 32'(tx_reads - base_tx), 32'd3);
    check("b2b_rx_count", 32'(rx_q.size()), 32'd3);
    check("b2b_rx0", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD, 32'h11);
    check("b2b_rx1", (rx_q.size() > 1) ? rx_q[1] : 32'hDEAD, 32'h22);
    check("b2b_rx2", (rx_q.size() > 2) ? rx_q[2] : 32'hDEAD, 32'h33);
    check("b2b_gap1", (gaps.size() > 1) ? 32'(gaps[1]) : 32'hDEAD, 32'd3);
    check("b2b_gap2", (gaps.size() > 2) ? 32'(gaps[2]) : 32'hDEAD, 32'd3);
    check("b2b_busy_end", 32'(bus.Busy), 32'd0);

    // RX FIFO full for a whole frame.
    bus.BaudDiv = 8'd1; bus.RxFull = 1'b1;
    snap();
    run_word(32'h5A);
    check("full_drop",   32'(rx_drops - base_dr), 32'd1);
    check("full_write",  32'(rx_writes - base_wr), 32'd0);
    check("full_rxdata", bus.RxData, 32'h5A);
    check("full_busy",   32'(bus.Busy), 32'd0);
    bus.RxFull = 1'b0;

    // Width boundaries: 32-bit and 1-bit frames.
    bus.BaudDiv = 8'd0; bus.WordSize = 5'd31;
    snap();
    run_word(32'h8000_0001);
    check("w32_mosi_bits", mosi_bits, 32'h8000_0001);
    check("w32_rises",     32'(rises), 32'd32);
    check("w32_rxdata",    bus.RxData, 32'h8000_0001);
    check("w32_cs_low",    32'(last_cs_low), 32'd66);
    bus.WordSize = 5'd0;
    snap();
    run_word(32'h0000_0001);
    check("w1_mosi_bits", mosi_bits, 32'h1);
    check("w1_rises",     32'(rises), 32'd1);
    check("w1_rxdata",    bus.RxData, 32'h1);
    check("w1_cs_low",    32'(last_cs_low), 32'd4);

    // Reset asserted in the middle of SHIFT.
    bus.BaudDiv = 8'd3; bus.WordSize = 5'd7;
    snap();
    tx_q.push_back(32'hFF);
    wait_cs(1'b0, 50);
    tick(5);
    check("pre_rst_sclk", 32'(bus.SCLK), 32'd1);
    Reset = 1'b1;
    #1;
    check("arst_csn",  32'(bus.CS_n), 32'd1);
    check("arst_sclk", 32'(bus.SCLK), 32'd0);
    check("arst_busy", 32'(bus.Busy), 32'd0);
    tick(3);
    Reset = 1'b0;
    tick(4);
    check("arst_no_write", 32'(rx_writes - base_wr), 32'd0);
    check("arst_idle",     32'(bus.Busy), 32'd0);

    // Enable dropped mid-frame: frame completes, no further pop.
    bus.BaudDiv = 8'd1;
    snap();
    tx_q.push_back(32'h96); tx_q.push_back(32'h69);
    wait_cs(1'b0, 50);
    bus.Enable = 1'b0;
    wait_busy(1'b0, 200);
    tick(20);
    check("endrop_txreads", 32'(tx_reads - base_tx), 32'd1);
    check("endrop_rxdata",  (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD, 32'h96);
    check("endrop_txleft",  32'(tx_q.size()), 32'd1);
    bus.Enable = 1'b1;
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 200);
    tick(1);
    check("resume_rxdata",  bus.RxData, 32'h69);
    check("txread_nonempty", 32'(txread_empty), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
